sap_run_ctrl: RTL
=================

# sap_run_ctrl

Run/step/halt sequencer for the SAP-1 core. Derives the one-cycle `clken` (virtual-clock rising edge) and `clken_oop` (falling edge) enables from `sysclk`, produces the front-panel clear pulse, and stops the virtual clock cleanly when the core raises `halt`. It sits between the front-panel switches and the `sap1` instance, replacing the free-running enable divider used in simulation.

## Interface
- `CLKLEN`, 4: sysclk cycles per virtual-clock half-period; legal values are 2 to 255.
- `CLR_CYCLES`, 8: length of the `fp_clear` pulse in sysclk cycles; legal values are 1 to 255.

- `sysclk`  in  1  sole clock; all logic on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `run_sw`  in  1  level input, synchronous to `sysclk`: 1 = run continuously, 0 = step mode.
- `step_btn`  in  1  synchronous level; each 0→1 edge requests one virtual cycle.
- `clear_btn`  in  1  synchronous level; while high, forces the clear sequence.
- `halt`  in  1  halt flag from the SAP core.
- `clken`  out  1  one-cycle pulse at the virtual rising edge.
- `clken_oop`  out  1  one-cycle pulse at the virtual falling edge.
- `vclk`  out  1  virtual clock level, for display.
- `fp_clear`  out  1  active-high clear to the core.
- `running`  out  1  high in RUN and STEP.

## Operation
- States:
  - CLEAR: `fp_clear`=1; the clear counter counts CLR_CYCLES, then the block moves to IDLE.
  - IDLE
  - RUN
  - STEP
  - DRAIN: finishes the current virtual cycle.
  - HALTED
- Transition priority, highest first:
  - `clear_btn`=1 in any state → CLEAR, with the counter restarted.
  - In IDLE, `halt`=1 → HALTED.
  - In IDLE, `run_sw`=1 → RUN.
  - In IDLE, a `step_btn` rising edge → STEP. If `run_sw` and a step edge arrive together, run wins.
- RUN:
  - `run_sw`=0 → DRAIN with target IDLE.
  - `halt`=1 → DRAIN with target HALTED.
- STEP: after its `clken_oop` is issued, the block returns to IDLE, or to HALTED if `halt`=1.
- DRAIN: no new `clken` is issued. When `vclk`=1, the pending `clken_oop` is still issued. The block then goes to its target state. If `vclk`=0 on entry, it exits on the next cycle.
- HALTED: every input except `clear_btn` is ignored. The only exit is CLEAR, and the core's `halt` clears under `fp_clear`.
- Step edges outside IDLE are dropped, not queued.
- Divider:
  - Count runs 0..CLKLEN-1 only in RUN, STEP and DRAIN. Otherwise count=0 and `vclk`=0.
  - At count==CLKLEN-1: count→0 and `vclk` toggles.
  - On that toggle, the registered pulse is `clken` if the old `vclk` was 0, and `clken_oop` if it was 1.
- Step edge detect: one register holds the previous `step_btn`. It resets to 1, so a button already held at reset does not step.

## Timing
- Reset values, asserted asynchronously while `reset_n`=0:
  - state = CLEAR, clear counter = 0, divider count = 0
  - `clken`=0, `clken_oop`=0, `vclk`=0, `running`=0
  - `fp_clear`=1
- After `reset_n` rises, `fp_clear` stays high for exactly CLR_CYCLES cycles.
- State entry and first edges:
  - RUN or STEP is entered one cycle after the qualifying input is sampled.
  - The first `clken` is high on the cycle CLKLEN cycles after the entry cycle.
  - `clken_oop` follows CLKLEN cycles after `clken`.
- In RUN the period is 2·CLKLEN cycles. `clken` and `clken_oop` are each exactly one cycle wide and are never high together.
- `halt` is sampled every cycle. Once `halt` is seen, no `clken` follows it.
- `running` is registered and is high exactly in RUN and STEP.

## Configuration
- `SAP_RUN_CTRL_STEP_EN` defined: step mode is present, as described above.
- `SAP_RUN_CTRL_STEP_EN` undefined:
  - The STEP state and the step edge register are removed.
  - `step_btn` is ignored, and IDLE exits only on `run_sw` or `halt`.
  - All other behaviour and timing are identical.

## Structure
- Shared `sap_pkg`: the state encoding `run_state_t` (CLEAR, IDLE, RUN, STEP, DRAIN, HALTED), and the default values for CLKLEN and CLR_CYCLES.
- Sub-module `sap_clken_div`:
  - Divider plus the `vclk`/`clken`/`clken_oop` registers.
  - Inputs: `enable` and `stop_after_fall`.
  - Output: `at_rest` (vclk=0 and no pulse pending).
- The top level holds the FSM, the clear counter and the edge detect.

## Test plan
All scenarios use CLKLEN=4 and CLR_CYCLES=8.
- Release `reset_n` → `fp_clear`=1 for 8 cycles, then 0; `clken`/`clken_oop` stay 0; `running`=0.
- `run_sw`=1 from IDLE → `running`=1; `clken` at cycles 4, 12, 20 after RUN entry; `clken_oop` at 8, 16, 24; `vclk` toggles every 4 cycles.
- Step mode, one `step_btn` edge → exactly one `clken`, then one `clken_oop` 4 cycles later; no pulses for 50 cycles; a second edge during STEP produces nothing extra.
- RUN, `halt`=1 one cycle after a `clken` → one `clken_oop` 3 cycles later, then silence. Toggling `run_sw`/`step_btn` has no effect. `clear_btn` pulse → `fp_clear` for 8 cycles → IDLE.
- RUN, `run_sw`→0 while `vclk`=1 → the pending `clken_oop` is issued, then IDLE with `vclk`=0.
- `reset_n`→0 mid-RUN while `vclk`=1 → in the same cycle all pulses are 0, `vclk`=0 and `fp_clear`=1; recovery as in the first scenario.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared types and defaults for the SAP-1 run/step/halt sequencer.
// State encoding plus default divider and clear-pulse lengths.
package sap_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    RUN,
    STEP,
    DRAIN,
    HALTED
  } run_state_t;

  localparam int unsigned CLKLEN_DEF     = 4;
  localparam int unsigned CLR_CYCLES_DEF = 8;

  function automatic logic is_active(run_state_t s);
    return (s == RUN) || (s == STEP) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/sap_clken_div.sv
// Virtual-clock divider: vclk level plus one-cycle rise/fall enables.
// stop_after_fall lets a pending fall complete but blocks the next rise.
module sap_clken_div
  import sap_pkg::*;
#(
  parameter int unsigned CLKLEN = CLKLEN_DEF
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic enable,
  input  logic stop_after_fall,
  output logic vclk,
  output logic clken,
  output logic clken_oop,
  output logic at_rest
);

  localparam logic [7:0] LAST = 8'(CLKLEN - 1);

  logic [7:0] count;

  // half-period counter; toggles vclk and registers the matching pulse
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      vclk      <= 1'b0;
      clken     <= 1'b0;
      clken_oop <= 1'b0;
    end else if (!enable) begin
      count     <= '0;
      vclk      <= 1'b0;
      clken     <= 1'b0;
      clken_oop <= 1'b0;
    end else begin
      clken     <= 1'b0;
      clken_oop <= 1'b0;
      if (count == LAST) begin
        count <= '0;
        if (!(stop_after_fall && !vclk)) begin
          vclk      <= ~vclk;
          clken     <= ~vclk;
          clken_oop <= vclk;
        end
      end else begin
        count <= count + 8'd1;
      end
    end
  end

  assign at_rest = ~vclk & ~clken;

endmodule

// File: rtl/sap_run_ctrl.sv
// Run/step/halt sequencer feeding clken/clken_oop and fp_clear to the SAP-1.
// Step mode is built only when SAP_RUN_CTRL_STEP_EN is defined.
module sap_run_ctrl
  import sap_pkg::*;
#(
  parameter int unsigned CLKLEN     = CLKLEN_DEF,
  parameter int unsigned CLR_CYCLES = CLR_CYCLES_DEF
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic run_sw,
  input  logic step_btn,
  input  logic clear_btn,
  input  logic halt,
  output logic clken,
  output logic clken_oop,
  output logic vclk,
  output logic fp_clear,
  output logic running
);

  localparam logic [7:0] CLR_LAST = 8'(CLR_CYCLES - 1);

  run_state_t state, state_n;
  run_state_t tgt, tgt_n;
  logic [7:0] clr_cnt;
  logic       step_rise;
  logic       at_rest;
  logic       div_en;
  logic       div_stop;

`ifdef SAP_RUN_CTRL_STEP_EN
  logic step_q;

  // previous step_btn; resets high so a held button does not step
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) step_q <= 1'b1;
    else          step_q <= step_btn;
  end

  assign step_rise = step_btn & ~step_q;
`else
  logic unused_step;
  assign unused_step = step_btn;
  assign step_rise   = 1'b0;
`endif

  // next-state and drain target selection
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    if (clear_btn) begin
      state_n = CLEAR;
    end else begin
      unique case (state)
        CLEAR: begin
          if (clr_cnt == CLR_LAST) state_n = IDLE;
        end
        IDLE: begin
          if (halt)           state_n = HALTED;
          else if (run_sw)    state_n = RUN;
          else if (step_rise) state_n = STEP;
        end
        RUN: begin
          if (!run_sw) begin
            state_n = DRAIN;
            tgt_n   = IDLE;
          end else if (halt) begin
            state_n = DRAIN;
            tgt_n   = HALTED;
          end
        end
        STEP: begin
          if (clken_oop) begin
            state_n = halt ? HALTED : IDLE;
          end else if (halt) begin
            state_n = DRAIN;
            tgt_n   = HALTED;
          end
        end
        DRAIN: begin
          if (at_rest) state_n = tgt;
        end
        HALTED: begin
          state_n = HALTED;
        end
        default: begin
          state_n = CLEAR;
        end
      endcase
    end
  end

  // state, drain target and registered running flag
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      tgt     <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_n;
      tgt     <= tgt_n;
      running <= (state_n == RUN) || (state_n == STEP);
    end
  end

  // clear pulse length counter, restarted by clear_btn
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt <= '0;
    end else if (clear_btn || state != CLEAR) begin
      clr_cnt <= '0;
    end else begin
      clr_cnt <= clr_cnt + 8'd1;
    end
  end

  assign fp_clear = (state == CLEAR);
  assign div_en   = is_active(state) && is_active(state_n);
  assign div_stop = (state_n == DRAIN);

  sap_clken_div #(
    .CLKLEN(CLKLEN)
  ) u_div (
    .sysclk         (sysclk),
    .reset_n        (reset_n),
    .enable         (div_en),
    .stop_after_fall(div_stop),
    .vclk           (vclk),
    .clken          (clken),
    .clken_oop      (clken_oop),
    .at_rest        (at_rest)
  );

endmodule
